// File: rtl/hall_speed_sched.sv
// Hall-sensor speed measurement controller.
// Synchronises the raw hall bus, qualifies each transition against the
// 6-step commutation sequence and counts legal steps over a fixed gate window.
// At each window boundary the step count, direction, error and overflow status
// are latched and a one-cycle valid strobe is raised.
//
// Ports:
//   inclk     system clock
//   rst_n     asynchronous active-low reset
//   en        measurement enable (level); rising start goes through a priming cycle
//   h[2:0]    raw hall inputs (asynchronous)
//   count     legal steps in the last completed window (saturating)
//   dir       1 = forward, 0 = reverse (last legal step seen)
//   hall_err  illegal state or non-adjacent jump seen in the last window
//   overflow  step counter saturated in the last window
//   valid     one-cycle strobe: outputs were just updated
module hall_speed_sched #(
    parameter int unsigned GATE_CYCLES = 3163478,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             inclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       h,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             hall_err,
    output logic             overflow,
    output logic             valid
);

    localparam int unsigned TMR_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned SYNC_W = SYNC_N * 3;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] K_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRIME   = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [SYNC_W-1:0] sync_q;
    logic [2:0]        h_s;

    logic [TMR_W-1:0] timer, timer_nx;
    logic [CNT_W-1:0] k, k_nx;
    logic [2:0]       h_prev, h_prev_nx;
    logic             dir_win, dir_win_nx;
    logic             err_win, err_win_nx;
    logic             ovf_win, ovf_win_nx;

    logic [CNT_W-1:0] count_nx;
    logic             dir_nx, hall_err_nx, overflow_nx, valid_nx;

    logic changed, both_legal, step_fwd, step_rev;

    // Forward successor in the commutation sequence; 000 for illegal states.
    function automatic logic [2:0] fwd_next(input logic [2:0] s);
        case (s)
            3'b001:  return 3'b011;
            3'b011:  return 3'b010;
            3'b010:  return 3'b110;
            3'b110:  return 3'b100;
            3'b100:  return 3'b101;
            3'b101:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] s);
        return (s != 3'b000) && (s != 3'b111);
    endfunction

    // Metastability synchroniser; h_s is the oldest stage.
    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_W-4:0], h};
        end
    end

    assign h_s = sync_q[SYNC_W-1 -: 3];

    // Transition qualification against the previously accepted hall state.
    always_comb begin
        changed    = (h_s != h_prev);
        both_legal = is_legal(h_s) && is_legal(h_prev);
        step_fwd   = changed && both_legal && (h_s == fwd_next(h_prev));
        step_rev   = changed && both_legal && (h_prev == fwd_next(h_s));
    end

    // State register.
    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        k_nx        = k;
        h_prev_nx   = h_prev;
        dir_win_nx  = dir_win;
        err_win_nx  = err_win;
        ovf_win_nx  = ovf_win;
        count_nx    = count;
        dir_nx      = dir;
        hall_err_nx = hall_err;
        overflow_nx = overflow;
        valid_nx    = 1'b0;

        case (state)
            ST_IDLE: begin
                timer_nx   = '0;
                k_nx       = '0;
                err_win_nx = 1'b0;
                ovf_win_nx = 1'b0;
                if (en) begin
                    state_nx = ST_PRIME;
                end
            end

            // Load the reference hall state so the first compare is against live data.
            ST_PRIME: begin
                h_prev_nx = h_s;
                timer_nx  = '0;
                state_nx  = ST_MEASURE;
            end

            ST_MEASURE: begin
                if (!en) begin
                    // Partial window is dropped without a strobe.
                    state_nx   = ST_IDLE;
                    timer_nx   = '0;
                    k_nx       = '0;
                    err_win_nx = 1'b0;
                    ovf_win_nx = 1'b0;
                end else begin
                    h_prev_nx = h_s;
                    if (step_fwd || step_rev) begin
                        if (k == K_MAX) begin
                            ovf_win_nx = 1'b1;
                        end else begin
                            k_nx = k + CNT_W'(1);
                        end
                        dir_win_nx = step_fwd;
                    end else if (changed) begin
                        err_win_nx = 1'b1;
                    end

                    // Boundary latches the step-updated window values.
                    if (timer == TMR_LAST) begin
                        count_nx    = k_nx;
                        dir_nx      = dir_win_nx;
                        hall_err_nx = err_win_nx;
                        overflow_nx = ovf_win_nx;
                        valid_nx    = 1'b1;
                        timer_nx    = '0;
                        k_nx        = '0;
                        err_win_nx  = 1'b0;
                        ovf_win_nx  = 1'b0;
                    end else begin
                        timer_nx = timer + TMR_W'(1);
                    end
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= '0;
            k        <= '0;
            h_prev   <= 3'b000;
            dir_win  <= 1'b0;
            err_win  <= 1'b0;
            ovf_win  <= 1'b0;
            count    <= '0;
            dir      <= 1'b0;
            hall_err <= 1'b0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            timer    <= timer_nx;
            k        <= k_nx;
            h_prev   <= h_prev_nx;
            dir_win  <= dir_win_nx;
            err_win  <= err_win_nx;
            ovf_win  <= ovf_win_nx;
            count    <= count_nx;
            dir      <= dir_nx;
            hall_err <= hall_err_nx;
            overflow <= overflow_nx;
            valid    <= valid_nx;
        end
    end

endmodule

// File: tb/tb_hall_speed_sched.sv
// Bench for hall_speed_sched: two instances (CNT_W=8 and CNT_W=4) share the
// same stimulus; a window-level model pushes expected results that are popped
// and compared whenever valid strobes.
module tb_hall_speed_sched;

    logic       inclk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] h;

    logic [7:0] count8;
    logic [3:0] count4;
    logic       dir8, dir4, err8, err4, ovf8, ovf4, valid8, valid4;

    hall_speed_sched #(.GATE_CYCLES(100), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .inclk(inclk), .rst_n(rst_n), .en(en), .h(h),
        .count(count8), .dir(dir8), .hall_err(err8), .overflow(ovf8), .valid(valid8)
    );

    hall_speed_sched #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .inclk(inclk), .rst_n(rst_n), .en(en), .h(h),
        .count(count4), .dir(dir4), .hall_err(err4), .overflow(ovf4), .valid(valid4)
    );

    always #5 inclk = ~inclk;

    int cyc = 0;
    always @(posedge inclk) cyc <= cyc + 1;

    typedef struct {
        int vcyc;
        int cnt8;
        int ovf8;
        int cnt4;
        int ovf4;
        int dir;
        int err;
    } exp_t;

    typedef struct {
        int         slot;
        logic [2:0] hv;
    } step_t;

    exp_t  sb[$];
    exp_t  last_exp;
    exp_t  mon_e;
    step_t plan[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] fwd_tab [8];
    logic [2:0] rev_tab [8];

    // Window model state
    int         c0;
    int         nxt_win;
    logic [2:0] prev_h;
    logic [2:0] plan_h;
    int a8, a4, o8, o4, dm, er;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit lg(input logic [2:0] v);
        return (v != 3'b000) && (v != 3'b111);
    endfunction

    task automatic clear_acc();
        a8 = 0; a4 = 0; o8 = 0; o4 = 0; er = 0;
    endtask

    task automatic count_step(input int f);
        if (a8 == 255) o8 = 1; else a8++;
        if (a4 == 15)  o4 = 1; else a4++;
        dm = f;
    endtask

    // Drive a new hall value and fold it into the current window model.
    task automatic apply_h(input logic [2:0] v);
        if (v != prev_h) begin
            if (lg(prev_h) && lg(v) && fwd_tab[prev_h] == v)      count_step(1);
            else if (lg(prev_h) && lg(v) && fwd_tab[v] == prev_h) count_step(0);
            else                                                  er = 1;
        end
        prev_h = v;
        h      = v;
    endtask

    task automatic close_window(input int w);
        exp_t e;
        e.vcyc = c0 + 102 + 100 * w;
        e.cnt8 = a8; e.ovf8 = o8; e.cnt4 = a4; e.ovf4 = o4;
        e.dir  = dm; e.err  = er;
        sb.push_back(e);
        last_exp = e;
        clear_acc();
    endtask

    task automatic pfwd(input int s);
        plan_h = fwd_tab[plan_h];
        plan.push_back('{s, plan_h});
    endtask

    task automatic prev_step(input int s);
        plan_h = rev_tab[plan_h];
        plan.push_back('{s, plan_h});
    endtask

    task automatic praw(input int s, input logic [2:0] v);
        plan_h = v;
        plan.push_back('{s, v});
    endtask

    task automatic start_measure();
        @(negedge inclk);
        en      = 1'b1;
        c0      = cyc;
        nxt_win = 0;
        clear_acc();
    endtask

    // Walk slots relative to the enable point; slot s drives h just before posedge s.
    task automatic run_to(input int end_slot, input int drop_slot);
        int s;
        while (1) begin
            s = cyc - c0;
            if (s == 100 * (nxt_win + 1)) begin
                close_window(nxt_win);
                nxt_win++;
            end
            if (s == drop_slot) begin
                en = 1'b0;
                clear_acc();
                return;
            end
            if (s >= end_slot) return;
            foreach (plan[i]) if (plan[i].slot == s) apply_h(plan[i].hv);
            @(negedge inclk);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, "_count8"}, count8, e.cnt8);
        check({tag, "_count4"}, count4, e.cnt4);
        check({tag, "_dir"},    {dir8, dir4}, {e.dir[0], e.dir[0]});
        check({tag, "_err"},    {err8, err4}, {e.err[0], e.err[0]});
        check({tag, "_ovf8"},   ovf8, e.ovf8);
        check({tag, "_ovf4"},   ovf4, e.ovf4);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected window.
    always @(negedge inclk) begin
        if (rst_n === 1'b1 && (valid8 !== 1'b0 || valid4 !== 1'b0)) begin
            if (sb.size() == 0) begin
                check("spurious_valid", {valid8, valid4}, 2'b00);
            end else begin
                mon_e = sb.pop_front();
                check("valid_cycle", cyc, mon_e.vcyc);
                check("valid_both", {valid8, valid4}, 2'b11);
                check_outputs("win", mon_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t zero_e;
        fwd_tab = '{3'b000, 3'b011, 3'b110, 3'b010, 3'b101, 3'b001, 3'b100, 3'b000};
        rev_tab = '{3'b000, 3'b101, 3'b011, 3'b001, 3'b110, 3'b100, 3'b010, 3'b000};
        zero_e  = '{0, 0, 0, 0, 0, 0, 0};
        dm = 0;
        clear_acc();

        // Reset held, then released with en low and h wandering.
        rst_n = 1'b0;
        en    = 1'b0;
        h     = 3'b000;
        repeat (3) begin
            @(negedge inclk);
            h = 3'($urandom_range(0, 7));
        end
        check_outputs("reset", zero_e);
        check("reset_valid", {valid8, valid4}, 2'b00);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge inclk);
            h = 3'($urandom_range(0, 7));
        end
        check_outputs("idle", zero_e);
        h      = 3'b001;
        prev_h = 3'b001;
        plan_h = 3'b001;
        repeat (5) @(negedge inclk);

        // Windows 0..6 with a drop at timer 50 of window 6.
        pfwd(10); pfwd(20); pfwd(30); pfwd(40);            // 4 forward
        prev_step(120); prev_step(140);                    // 2 reverse
        praw(310, 3'b111); praw(320, 3'b001);              // illegal, then jump
        praw(330, 3'b010); pfwd(340); pfwd(350);           // 2 legal after errors
        prev_step(420);                                    // clean window
        for (int i = 1; i <= 20; i++) pfwd(500 + 4 * i);   // saturate CNT_W=4
        pfwd(599);                                         // lands on timer==99
        pfwd(600);                                         // first cycle of next window
        start_measure();
        run_to(100000, 652);

        // Disabled: nothing strobes and outputs hold the last window.
        repeat (150) @(negedge inclk);
        check_outputs("hold", last_exp);
        check("hold_sb_empty", sb.size(), 0);

        // Re-enable for a full window, then async reset mid-window.
        plan.delete();
        pfwd(10); pfwd(20);
        prev_step(130);
        start_measure();
        run_to(150, -1);
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", zero_e);
        check("async_rst_valid", {valid8, valid4}, 2'b00);
        en = 1'b0;
        repeat (3) @(negedge inclk);
        rst_n = 1'b1;
        repeat (20) @(negedge inclk);
        check_outputs("post_rst", zero_e);
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
